// File: rtl/main_write_drain_if.sv
// main_write_drain_if: FIFO read-side and main-memory write-port signals of the write drain.
// Latency: none, wires only.
// Backpressure: none here; the drain holds mem_wr_req until mem_wr_ack or its timeout.
// Modports: master = drain side (drives fifo_is_read, mem_wr_req/addr/data),
//           slave  = FIFO + memory side (drives fifo_empty/is_write/read_*, mem_wr_ack).
interface main_write_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_is_write;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic [ADDR_WIDTH-1:0] fifo_read_addr;
  logic                  fifo_is_read;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_ack;

  modport master (
    input  fifo_empty, fifo_is_write, fifo_read_data, fifo_read_addr, mem_wr_ack,
    output fifo_is_read, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output fifo_empty, fifo_is_write, fifo_read_data, fifo_read_addr, mem_wr_ack,
    input  fifo_is_read, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/main_write_drain.sv
// main_write_drain: pops the write-back FIFO and issues one main-memory write per entry.
// Latency: pop at N, capture at N+1, mem_wr_req from N+2; one write per 3 cycles peak.
// Backpressure: one entry in flight; no pop until the current write is acked or dropped.
// Ports: clk/reset (sync, active high); bus = FIFO read side + memory write port;
//        flush -> flush_done; busy (not IDLE); err (sticky drop); wr_count (acked writes).
module main_write_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               reset,
  main_write_drain_if.master bus,
  input  logic               flush,
  output logic               flush_done,
  output logic               busy,
  output logic               err,
  output logic [15:0]        wr_count
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REQ     = 2'd2,
    BACKOFF = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [TW-1:0]         timer;
  logic [RW-1:0]         retry;
  logic [RW-1:0]         retry_inc;
  logic                  timed_out;
  logic                  last_retry;
  logic                  pop;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign timed_out  = (timer == TW'(TIMEOUT));
  assign retry_inc  = retry + RW'(1);
  assign last_retry = (retry_inc == RW'(MAX_RETRY));

  // The FIFO drops a pop that coincides with its own write, so never issue one then.
  assign pop = ~reset & (state == IDLE) & ~bus.fifo_empty & ~bus.fifo_is_write;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = CAPTURE;
      CAPTURE: next_state = REQ;
      // Ack wins over a timeout landing in the same cycle.
      REQ: begin
        if (bus.mem_wr_ack) begin
          next_state = IDLE;
        end else if (timed_out) begin
          next_state = BACKOFF;
        end
      end
      BACKOFF: next_state = last_retry ? IDLE : REQ;
      default: next_state = IDLE;
    endcase
  end

  // Combinational output: the FIFO pop strobe
  always_comb begin
    bus.fifo_is_read = pop;
  end

  // Registered outputs and datapath; req/busy are taken from next_state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      flush_done <= 1'b0;
      err        <= 1'b0;
      wr_count   <= 16'd0;
      busy       <= 1'b0;
      timer      <= '0;
      retry      <= '0;
    end else begin
      req_q      <= (next_state == REQ);
      busy       <= (next_state != IDLE);
      flush_done <= flush & (state == IDLE) & bus.fifo_empty;
      case (state)
        CAPTURE: begin
          addr_q <= bus.fifo_read_addr;
          data_q <= bus.fifo_read_data;
          timer  <= '0;
          retry  <= '0;
        end
        REQ: begin
          if (bus.mem_wr_ack) begin
            wr_count <= wr_count + 16'd1;
          end else if (!timed_out) begin
            timer <= timer + TW'(1);
          end
        end
        BACKOFF: begin
          retry <= retry_inc;
          timer <= '0;
          if (last_retry) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_wr_req  = req_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = data_q;
endmodule

// File: tb/tb_main_write_drain.sv
// tb_main_write_drain: randomized + directed bench for main_write_drain with a FIFO model,
// a scheduled memory responder and a scoreboard monitor.
// Latency/backpressure expectations come from the per-entry ack schedule in the scoreboard.
module tb_main_write_drain;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int MR = 3;
  localparam int NA = TO + 3;  // ack offset that never arrives inside a window

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            d [MR];     // ack offset for each attempt; > TO means no ack
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        flush_done;
  logic        busy;
  logic        err;
  logic [15:0] wr_count;
  logic        rst_q;

  main_write_drain_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  main_write_drain #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush),
    .flush_done(flush_done), .busy(busy), .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t             exp_q [$];
  ent_t             rsp_q [$];
  logic [AW+DW-1:0] fq    [$];
  logic [AW-1:0]    push_addr;
  logic [DW-1:0]    push_data;

  always @(posedge clk) rst_q <= reset;

  // FIFO model: pop ignored while a write is in progress; outputs valid the cycle after a pop.
  always @(posedge clk) begin : fifo_model
    logic [AW+DW-1:0] w;
    if (bus.fifo_is_read && !bus.fifo_is_write && fq.size() > 0) begin
      w = fq.pop_front();
      bus.fifo_read_addr <= w[AW+DW-1:DW];
      bus.fifo_read_data <= w[DW-1:0];
    end
    if (bus.fifo_is_write) fq.push_back({push_addr, push_data});
    bus.fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  function automatic int wlen(input int d);
    return (d <= TO) ? d + 1 : TO + 1;
  endfunction

  // Memory responder: acks each REQ window at the offset scheduled for that attempt,
  // and throws stray acks while no request is up.
  ent_t r_cur;
  bit   r_v    = 0;
  bit   r_prev = 0;
  int   r_k    = 0;
  int   r_off  = 0;
  initial begin : responder
    bus.mem_wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.mem_wr_ack = 1'b0;
      if (rst_q) begin
        r_v    = 0;
        r_prev = 0;
      end else begin
        if (bus.mem_wr_req) begin
          if (!r_prev) begin
            if (!r_v) begin
              if (rsp_q.size() == 0) begin
                failures++;
                $display("FAIL responder_no_entry t=%0t actual=req required=no_req", $time);
              end else begin
                r_cur = rsp_q.pop_front();
                r_v   = 1;
                r_k   = 0;
              end
            end else begin
              r_k++;
            end
            r_off = 0;
          end else begin
            r_off++;
          end
          if (r_v && r_k < MR && r_cur.d[r_k] == r_off) begin
            bus.mem_wr_ack = 1'b1;
            r_v            = 0;
          end
        end else begin
          if (r_prev && r_v && r_k == MR - 1) r_v = 0;
          bus.mem_wr_ack = ($urandom_range(0, 7) == 0);
        end
        r_prev = bus.mem_wr_req;
      end
    end
  end

  // Scoreboard monitor: tracks one in-flight entry through its request windows.
  ent_t        m_cur;
  bit          m_inflight  = 0;
  int          m_cyc       = 0;
  int          m_idle_from = 0;
  int          m_k         = 0;
  int          m_win_start = 0;
  int          m_win_len   = 0;
  bit          m_drop_pend = 0;
  int          m_drop_at   = 0;
  logic [15:0] m_cnt       = 16'd0;
  logic        m_err       = 1'b0;
  logic        m_fd        = 1'b0;

  always @(negedge clk) begin : monitor
    logic idle;
    logic exp_req;
    logic exp_pop;
    m_cyc++;
    if (rst_q) begin
      m_inflight  = 0;
      m_cnt       = 16'd0;
      m_err       = 1'b0;
      m_drop_pend = 0;
      m_idle_from = m_cyc;
    end
    if (m_drop_pend && m_cyc == m_drop_at) begin
      m_err       = 1'b1;
      m_drop_pend = 0;
    end
    idle    = rst_q || (!m_inflight && m_cyc >= m_idle_from);
    exp_req = m_inflight && m_cyc >= m_win_start && m_cyc < m_win_start + m_win_len;
    exp_pop = !reset && idle && !bus.fifo_empty && !bus.fifo_is_write;

    chk("wr_count",     64'(wr_count),         64'(m_cnt));
    chk("err",          64'(err),              64'(m_err));
    chk("busy",         64'(busy),             64'(!idle));
    chk("flush_done",   64'(flush_done),       64'(m_fd));
    chk("mem_wr_req",   64'(bus.mem_wr_req),   64'(exp_req));
    chk("fifo_is_read", 64'(bus.fifo_is_read), 64'(exp_pop));
    if (rst_q) begin
      chk("reset_addr", 64'(bus.mem_wr_addr), 64'd0);
      chk("reset_data", 64'(bus.mem_wr_data), 64'd0);
    end
    if (exp_req) begin
      chk("mem_wr_addr", 64'(bus.mem_wr_addr), 64'(m_cur.addr));
      chk("mem_wr_data", 64'(bus.mem_wr_data), 64'(m_cur.data));
    end

    m_fd = !reset && flush && idle && bus.fifo_empty;

    if (exp_pop && bus.fifo_is_read) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_without_entry t=%0t actual=pop required=no_pop", $time);
      end else begin
        m_cur       = exp_q.pop_front();
        m_inflight  = 1;
        m_k         = 0;
        m_win_start = m_cyc + 2;
        m_win_len   = wlen(m_cur.d[0]);
      end
    end else if (exp_req && m_cyc == m_win_start + m_win_len - 1) begin
      if (m_cur.d[m_k] <= TO) begin
        m_cnt       = m_cnt + 16'd1;
        m_inflight  = 0;
        m_idle_from = m_cyc + 1;
      end else begin
        m_k++;
        if (m_k == MR) begin
          m_drop_pend = 1;
          m_drop_at   = m_cyc + 2;
          m_inflight  = 0;
          m_idle_from = m_cyc + 2;
        end else begin
          m_win_start = m_cyc + 2;
          m_win_len   = wlen(m_cur.d[m_k]);
        end
      end
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int a0, input int a1, input int a2);
    ent_t e;
    e.addr = a;
    e.data = d;
    e.d[0] = a0;
    e.d[1] = a1;
    e.d[2] = a2;
    exp_q.push_back(e);
    rsp_q.push_back(e);
    bus.fifo_is_write = 1'b1;
    push_addr         = a;
    push_data         = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int a0, input int a1, input int a2);
    issue(a, d, a0, a1, a2);
    tick();
  endtask

  task automatic stop_write();
    bus.fifo_is_write = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !m_inflight && m_cyc >= m_idle_from && !m_drop_pend) done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout t=%0t actual=pending=%0d required=0", $time, exp_q.size());
    end
  endtask

  initial begin : stimulus
    bit seen;
    reset             = 1'b1;
    flush             = 1'b0;
    bus.fifo_is_write = 1'b0;
    push_addr         = '0;
    push_data         = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single entry, ack on the first REQ cycle
    push(32'h100, 32'hDEADBEEF, 0, 0, 0);
    stop_write();
    drain(50);

    // Burst of four, zero-wait acks
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i * 4), $urandom, 0, 0, 0);
    stop_write();
    drain(100);

    // Pop collision: one entry queued, then the write strobe held for five more cycles
    push(32'h300, 32'h11110000, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(32'h304 + 32'(i * 4), $urandom, 1, 0, 0);
    stop_write();
    drain(150);

    // Timeout on every attempt: entry dropped, err set
    reset_pulse();
    push(32'h400, 32'hBAD0BAD0, NA, NA, NA);
    stop_write();
    drain(100);
    repeat (2) tick();

    // Second attempt acked on its final REQ cycle (ack beats timeout)
    reset_pulse();
    push(32'h404, 32'h600D600D, NA, TO, 0);
    stop_write();
    drain(100);

    // Flush with two entries queued
    flush = 1'b1;
    push(32'h500, $urandom, 1, 0, 0);
    push(32'h504, $urandom, 2, 0, 0);
    stop_write();
    drain(100);
    repeat (3) tick();
    flush = 1'b0;

    // Reset while in REQ; the rest of the FIFO drains afterwards
    push(32'h600, $urandom, NA, NA, NA);
    push(32'h604, $urandom, 0, 0, 0);
    push(32'h608, $urandom, 1, 0, 0);
    stop_write();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.mem_wr_req) seen = 1;
    end
    if (!seen) begin
      failures++;
      $display("FAIL wait_req_timeout t=%0t actual=no_req required=req", $time);
    end
    tick();
    reset_pulse();
    drain(200);

    // Randomized traffic with collisions, stalls, retries and flush toggling
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        issue($urandom, $urandom, $urandom_range(0, TO + 2),
              $urandom_range(0, TO + 2), $urandom_range(0, TO + 2));
      end else begin
        stop_write();
      end
      if ($urandom_range(0, 15) == 0) flush = ~flush;
      tick();
    end
    stop_write();
    flush = 1'b1;
    drain(3000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
